fir2d_kxk: RTL
==============

# fir2d_kxk

Parametrised 2D FIR filter for the luma video path. It sits between the RGB-to-Y converter and the HDMI transmitter, replacing the fixed 3x3 filter.

- Supports a KSIZE x KSIZE kernel (3 or 5) with runtime-loadable signed coefficients.
- Uses internal line buffers, zero-padded borders, normalisation shift and saturation.
- Has a fixed-latency pipeline that keeps dv/hs/vs aligned with the data.
- Outputs the filtered luma replicated on R, G and B.

## Interface
- DW, 8: pixel width (y_i, r_o/g_o/b_o).
- KSIZE, 3: kernel edge length; legal values 3 or 5.
- MAX_W, 2048: line-buffer depth, i.e. maximum active pixels per line.
- CW, 9: signed coefficient width.
- SHIFT, 4: arithmetic right-shift applied to the accumulated sum.

- clk  in  1: pixel clock; all logic rising-edge.
- rst  in  1: synchronous, active-high reset.
- coef_we  in  1: coefficient write strobe.
- coef_addr  in  clog2(KSIZE*KSIZE): coefficient index, i*KSIZE+j.
- coef_din  in  CW: signed coefficient value.
- bypass_i  in  1: 1 = pass luma unfiltered (see Configuration).
- y_i  in  DW: input luma.
- dv_i, hs_i, vs_i  in  1 each: input data-valid / hsync / vsync.
- r_o, g_o, b_o  out  DW each: output pixel, all three equal.
- dv_o, hs_o, vs_o  out  1 each: delayed syncs.

## Operation
- Window tap (i,j), with i,j in 0..KSIZE-1, is y(row-i, col-j).
  - The kernel is causal, anchored at the bottom-right; there is no centring offset.
  - Output(row,col) = sat((sum coef[i*KSIZE+j] * tap(i,j)) >>> SHIFT).
- Column counter:
  - Increments on each dv_i=1 cycle.
  - Clears on the dv_i falling edge and on the vs_i rising edge.
  - Saturates at MAX_W-1. Pixels at col >= MAX_W read zero for all taps with i>0 and are not written to the line buffers.
- Row counter:
  - Increments (saturating at KSIZE-1) on the dv_i falling edge.
  - Clears on the vs_i rising edge.
- Border rule: a tap with row-i<0 (i > row counter) or col-j<0 contributes zero. Stale line-buffer contents never reach the output.
- Line buffers: KSIZE-1 single-port-style RAMs of MAX_W x DW, chained. Each is written at the column address on dv_i=1.
- dv_i gaps inside a line stall the column counter. Window shift registers advance only on dv_i=1.
- Arithmetic:
  - Each tap is zero-extended to DW+1 signed and multiplied by a CW signed coefficient.
  - Accumulator width is DW+CW+clog2(KSIZE*KSIZE), so there is no overflow.
  - The shift is arithmetic.
  - Saturation clamps to [0, 2^DW-1].
- Coefficients:
  - Register file of KSIZE*KSIZE entries.
  - A write on coef_we=1 takes effect for pixels entering stage 1 on the next cycle.
  - coef_addr >= KSIZE*KSIZE is ignored.
  - Reset value is the identity kernel: coef[0]=1<<SHIFT, all others 0.
- Bypass: r_o=g_o=b_o = y_i delayed by the same latency, ignoring coefficients.
- hs_i is not interpreted; it is delayed only.

## Timing
- Latency is exactly 4 cycles, input to output, for data, dv, hs and vs.
  - S1: window/line-buffer read.
  - S2: multiply.
  - S3: adder tree.
  - S4: shift, saturate and register outputs.
- Throughput: one pixel per cycle, no backpressure.
- Reset (rst=1 at an edge):
  - The next cycle has all outputs at 0 and the pipeline flushed.
  - Row and column counters return to 0 and coefficients to identity.
  - Reset mid-frame means the following rows are treated as the top of a frame.
- Simultaneous events:
  - When the vs_i rise and the dv_i fall occur in the same cycle, the clear wins.
  - When coef_we hits the same cycle as a pixel in S2, the old coefficient is used.

## Configuration
- FIR2D_BYPASS_EN defined: bypass_i is functional as described.
- Undefined: bypass_i is ignored (treated as 0) and the bypass delay path is not built.

## Test plan
- Reset, identity kernel, 16-pixel line y=0..15 with dv_i → r_o=g_o=b_o=0..15 with dv/hs/vs shifted exactly 4 cycles.
- KSIZE=3, SHIFT=0, all coefficients 1, constant y=10 frame:
  - (row0,col0)=10, (row0,col1)=20, (row1,col1)=40, (row2,col2)=90.
  - (row3,col5)=90, showing the row counter saturates.
- Saturation: coef[0]=-16, y=100 → 0; coef[0]=255, SHIFT=4, y=255 → 255.
- vs_i rising mid-frame, then constant y=10 with all coefficients 1 → first line after vs gives col0=10 and col>=2 gives 30 (upper rows zero).
- With FIR2D_BYPASS_EN, bypass_i=1 and an all-ones kernel, ramp input → outputs equal the input delayed 4 cycles.
- Without FIR2D_BYPASS_EN, bypass_i=1 → filtered output.
- rst pulse mid-line after loading an all-ones kernel → next cycle all outputs 0. The next ramp line returns identity output.

Source files
------------

// File: rtl/fir2d_kxk_if.sv
// fir2d_kxk_if: coefficient port, luma/sync input and RGB/sync output of the 2D FIR.
// Latency: none, wires only.
// Backpressure: none; the video stream is free-running at one pixel per cycle.
interface fir2d_kxk_if #(
    parameter int DW    = 8,
    parameter int CW    = 9,
    parameter int KSIZE = 3
);
    localparam int AW = $clog2(KSIZE * KSIZE);

    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_din;
    logic                 bypass_i;
    logic [DW-1:0]        y_i;
    logic                 dv_i;
    logic                 hs_i;
    logic                 vs_i;
    logic [DW-1:0]        r_o;
    logic [DW-1:0]        g_o;
    logic [DW-1:0]        b_o;
    logic                 dv_o;
    logic                 hs_o;
    logic                 vs_o;

    modport master (
        output coef_we, coef_addr, coef_din, bypass_i, y_i, dv_i, hs_i, vs_i,
        input  r_o, g_o, b_o, dv_o, hs_o, vs_o
    );

    modport slave (
        input  coef_we, coef_addr, coef_din, bypass_i, y_i, dv_i, hs_i, vs_i,
        output r_o, g_o, b_o, dv_o, hs_o, vs_o
    );
endinterface

// File: rtl/fir2d_kxk.sv
// fir2d_kxk: causal KSIZE x KSIZE luma FIR, zero borders, shift + clamp; FIR2D_BYPASS_EN adds a bypass.
// Latency: 4 cycles for data, dv, hs and vs (S1 window, S2 multiply, S3 sum, S4 shift/clamp).
// Backpressure: none; accepts one pixel per cycle unconditionally.
module fir2d_kxk #(
    parameter int DW    = 8,
    parameter int KSIZE = 3,
    parameter int MAX_W = 2048,
    parameter int CW    = 9,
    parameter int SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    fir2d_kxk_if.slave bus
);
    localparam int NT   = KSIZE * KSIZE;
    localparam int XW   = $clog2(MAX_W);
    localparam int RW   = $clog2(KSIZE);
    localparam int NLB  = KSIZE - 1;
    localparam int PW   = DW + 1 + CW;
    localparam int ACCW = DW + CW + $clog2(NT);

    // ---------------------------------------------------------------
    // Position tracking
    // ---------------------------------------------------------------
    logic [XW-1:0] col;
    logic          col_ovf;
    logic [RW-1:0] row;
    logic          dv_d;
    logic          vs_d;
    logic          dv_fall;
    logic          vs_rise;

    assign dv_fall = dv_d & ~bus.dv_i;
    assign vs_rise = bus.vs_i & ~vs_d;

    // Column/row counters; a vsync rise clears both and wins over a dv fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            col_ovf <= 1'b0;
            row     <= '0;
            dv_d    <= 1'b0;
            vs_d    <= 1'b0;
        end else begin
            dv_d <= bus.dv_i;
            vs_d <= bus.vs_i;
            if (vs_rise || dv_fall) begin
                col     <= '0;
                col_ovf <= 1'b0;
            end else if (bus.dv_i) begin
                if (col == XW'(MAX_W - 1)) col_ovf <= 1'b1;
                else                       col     <= col + XW'(1);
            end
            if (vs_rise)                                row <= '0;
            else if (dv_fall && row != RW'(KSIZE - 1))  row <= row + RW'(1);
        end
    end

    // ---------------------------------------------------------------
    // Line buffers: lb[k] holds line row-1-k, read-before-write per column
    // ---------------------------------------------------------------
    logic [DW-1:0] lb    [NLB][MAX_W];
    logic [DW-1:0] lb_rd [NLB];

    // Read the stored column for every buffer at the current column address.
    always_comb begin
        for (int k = 0; k < NLB; k++) lb_rd[k] = lb[k][col];
    end

    // Push the current pixel in and age every stored line by one buffer.
    always_ff @(posedge clk) begin
        if (bus.dv_i && !col_ovf) begin
            lb[0][col] <= bus.y_i;
            for (int k = 1; k < NLB; k++) lb[k][col] <= lb_rd[k-1];
        end
    end

    // ---------------------------------------------------------------
    // Window: current column vector plus KSIZE-1 previous columns
    // ---------------------------------------------------------------
    logic [DW-1:0] vcol [KSIZE];
    logic [DW-1:0] hist [KSIZE][KSIZE-1];
    logic [DW-1:0] tap_c [NT];

    // Rows above the frame top or past the line-buffer depth read as zero.
    always_comb begin
        vcol[0] = bus.y_i;
        for (int k = 1; k < KSIZE; k++)
            vcol[k] = (RW'(k) <= row && !col_ovf) ? lb_rd[k-1] : '0;
    end

    // Column history shifts only on valid pixels so gaps do not skew the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KSIZE; i++)
                for (int j = 0; j < KSIZE - 1; j++) hist[i][j] <= '0;
        end else if (bus.dv_i) begin
            for (int i = 0; i < KSIZE; i++) begin
                hist[i][0] <= vcol[i];
                for (int j = 1; j < KSIZE - 1; j++) hist[i][j] <= hist[i][j-1];
            end
        end
    end

    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < KSIZE; gj++) begin : g_col
            logic [DW-1:0] raw;
            if (gj == 0) begin : g_now
                assign raw = vcol[gi];
            end else begin : g_old
                assign raw = hist[gi][gj-1];
            end
            // Left border and overflowed columns contribute zero.
            assign tap_c[gi*KSIZE+gj] =
                ((XW'(gj) > col) || ((gi > 0) && col_ovf)) ? '0 : raw;
        end
    end

    // ---------------------------------------------------------------
    // Coefficient register file
    // ---------------------------------------------------------------
    logic signed [CW-1:0] coef [NT];

    // Identity kernel at reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NT; n++) begin
                if (n == 0) coef[n] <= CW'(1 << SHIFT);
                else        coef[n] <= '0;
            end
        end else if (bus.coef_we && int'(bus.coef_addr) < NT) begin
            coef[bus.coef_addr] <= bus.coef_din;
        end
    end

    // ---------------------------------------------------------------
    // S1: window register
    // ---------------------------------------------------------------
    logic [DW-1:0] s1_tap [NT];
    logic [2:0]    sync_s1;
    logic [2:0]    sync_s2;
    logic [2:0]    sync_s3;

    // Capture the masked window and the syncs that travel with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NT; n++) s1_tap[n] <= '0;
            sync_s1 <= '0;
        end else begin
            for (int n = 0; n < NT; n++) s1_tap[n] <= tap_c[n];
            sync_s1 <= {bus.vs_i, bus.hs_i, bus.dv_i};
        end
    end

    // ---------------------------------------------------------------
    // S2: multiply (uses the coefficient value present this cycle)
    // ---------------------------------------------------------------
    logic signed [PW-1:0] prod_c [NT];
    logic signed [PW-1:0] s2_prod [NT];

    for (genvar gn = 0; gn < NT; gn++) begin : g_mul
        logic signed [PW-1:0] tap_s;
        logic signed [PW-1:0] coef_s;
        assign tap_s      = PW'($signed({1'b0, s1_tap[gn]}));
        assign coef_s     = PW'(coef[gn]);
        assign prod_c[gn] = tap_s * coef_s;
    end

    // Register the signed products.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NT; n++) s2_prod[n] <= '0;
            sync_s2 <= '0;
        end else begin
            for (int n = 0; n < NT; n++) s2_prod[n] <= prod_c[n];
            sync_s2 <= sync_s1;
        end
    end

    // ---------------------------------------------------------------
    // S3: adder tree, wide enough that it can never overflow
    // ---------------------------------------------------------------
    logic signed [ACCW-1:0] acc_c;
    logic signed [ACCW-1:0] s3_sum;

    // Sum all sign-extended products.
    always_comb begin
        acc_c = '0;
        for (int n = 0; n < NT; n++) acc_c = acc_c + ACCW'(s2_prod[n]);
    end

    // Register the accumulated sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_sum  <= '0;
            sync_s3 <= '0;
        end else begin
            s3_sum  <= acc_c;
            sync_s3 <= sync_s2;
        end
    end

    // ---------------------------------------------------------------
    // S4: arithmetic shift and clamp to [0, 2^DW-1]
    // ---------------------------------------------------------------
    logic signed [ACCW-1:0] shf_c;
    logic [DW-1:0]          sat_c;

    // Negative sums clamp to zero, anything above the pixel range to full scale.
    always_comb begin
        shf_c = s3_sum >>> SHIFT;
        if (shf_c[ACCW-1])           sat_c = '0;
        else if (|shf_c[ACCW-2:DW])  sat_c = '1;
        else                         sat_c = shf_c[DW-1:0];
    end

`ifdef FIR2D_BYPASS_EN
    logic          byp_s1, byp_s2, byp_s3;
    logic [DW-1:0] ybp_s1, ybp_s2, ybp_s3;

    // Raw luma and bypass select ride alongside the filter pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_s1 <= 1'b0;
            byp_s2 <= 1'b0;
            byp_s3 <= 1'b0;
            ybp_s1 <= '0;
            ybp_s2 <= '0;
            ybp_s3 <= '0;
        end else begin
            byp_s1 <= bus.bypass_i;
            byp_s2 <= byp_s1;
            byp_s3 <= byp_s2;
            ybp_s1 <= bus.y_i;
            ybp_s2 <= ybp_s1;
            ybp_s3 <= ybp_s2;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = bus.bypass_i;
`endif

    logic [DW-1:0] pix_q;
    logic          dv_q;
    logic          hs_q;
    logic          vs_q;

    // Output register: filtered (or bypassed) luma and the delayed syncs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            dv_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
`ifdef FIR2D_BYPASS_EN
            pix_q <= byp_s3 ? ybp_s3 : sat_c;
`else
            pix_q <= sat_c;
`endif
            {vs_q, hs_q, dv_q} <= sync_s3;
        end
    end

    assign bus.r_o  = pix_q;
    assign bus.g_o  = pix_q;
    assign bus.b_o  = pix_q;
    assign bus.dv_o = dv_q;
    assign bus.hs_o = hs_q;
    assign bus.vs_o = vs_q;
endmodule
